// File: rtl/tree_port_arbiter_if.sv
// Handshake bundle between the requesters, tree_port_arbiter and the downstream router port.
interface tree_port_arbiter_if #(
  parameter int WIDTH   = 34,
  parameter int NUM_REQ = 4
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ*WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]       in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;
  logic                     drop_pulse;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, drop_pulse
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, drop_pulse
  );
endinterface

// File: rtl/tree_port_arbiter.sv
// Round-robin N:1 packet arbiter with a single output register; dest==0 packets are dropped.
// Optional per-requester grant counters are enabled with macro TREE_ARB_GRANT_CNT_EN.
module tree_port_arbiter #(
  parameter int WIDTH_packet = 28,
  parameter int WIDTH_addr   = 3,
  parameter int WIDTH_dest   = 3,
  parameter int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
  parameter int NUM_REQ      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef TREE_ARB_GRANT_CNT_EN
  output logic [NUM_REQ*16-1:0] grant_cnt,
`endif
  tree_port_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      WIDTH != WIDTH_packet + WIDTH_addr + WIDTH_dest) begin : g_param_check
    $error("tree_port_arbiter: inconsistent parameters");
  end

  typedef enum logic {EMPTY, FULL} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   out_src_q, out_src_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               drop_q, drop_d;

  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic [WIDTH-1:0]   grant_pkt;
  logic               accept;
  logic               is_drop;
  logic               load;
  logic [NUM_REQ-1:0] in_ready;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    cand        = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_pkt = '0;
    in_ready  = '0;
    accept    = !rst && grant_found && (state_q == EMPTY || bus.out_ready);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        grant_pkt   = bus.in_data[k*WIDTH +: WIDTH];
        in_ready[k] = accept;
      end
    end
    is_drop = (grant_pkt[WIDTH_dest-1:0] == '0);
    load    = accept && !is_drop;
  end

  // Drain and reload may happen in the same cycle, so a load always wins over emptying.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    drop_d     = accept && is_drop;
    if (accept) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (load) begin
      state_d    = FULL;
      out_data_d = grant_pkt;
      out_src_d  = grant_idx;
    end else if (state_q == FULL && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.drop_pulse = drop_q;

`ifdef TREE_ARB_GRANT_CNT_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;

  // Counts every accepted packet including drops, saturating at all-ones.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (accept && grant_idx == PTR_W'(k) && grant_cnt_q[k] != 16'hFFFF) begin
        grant_cnt_d[k] = grant_cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif
endmodule

// File: tb/tb_tree_port_arbiter.sv
// Directed self-checking bench for tree_port_arbiter (4 requesters, 34-bit packets).
module tb_tree_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 34;

  logic clk = 1'b0;
  logic rst;
  int   checks_total  = 0;
  int   checks_passed = 0;
  logic [WIDTH-1:0] pk [NUM_REQ];
  logic [WIDTH-1:0] pk2b;

  tree_port_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

`ifdef TREE_ARB_GRANT_CNT_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  tree_port_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef TREE_ARB_GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] mkPkt(input logic [27:0] payload,
                                              input logic [2:0] addr,
                                              input logic [2:0] dest);
    return {payload, addr, dest};
  endfunction

  task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] v, input logic ordy);
    rst           = r;
    bus.in_valid  = v;
    bus.out_ready = ordy;
  endtask

  task automatic setSlot(input int i, input logic [WIDTH-1:0] p);
    bus.in_data[i*WIDTH +: WIDTH] = p;
  endtask

  task automatic loadSlots();
    for (int i = 0; i < NUM_REQ; i++) setSlot(i, pk[i]);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic expectRegs(input string tag, input logic v, input logic [WIDTH-1:0] d,
                            input logic [1:0] s, input logic dp);
    checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
    checkOutput({tag, ".out_data"},  64'(bus.out_data),  64'(d));
    checkOutput({tag, ".out_src"},   64'(bus.out_src),   64'(s));
    checkOutput({tag, ".drop"},      64'(bus.drop_pulse), 64'(dp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pk[0] = mkPkt(28'h1111111, 3'd0, 3'd1);
    pk[1] = mkPkt(28'h2222222, 3'd1, 3'd2);
    pk[2] = mkPkt(28'h3333333, 3'd2, 3'd3);
    pk[3] = mkPkt(28'h4444444, 3'd3, 3'd4);
    pk2b  = mkPkt(28'h5A5A5A5, 3'd2, 3'd5);
    bus.in_data = '0;

    // Reset: in_ready held low even with every requester valid
    applyStimulus(1'b1, 4'b1111, 1'b0);
    settle();
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    expectRegs("reset", 1'b0, '0, 2'd0, 1'b0);

    // All requesters valid, out_ready high: strict rotation 0,1,2,3,0,1,2,3
    loadSlots();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      settle();
      checkOutput($sformatf("rotate_in_ready_%0d", k), 64'(bus.in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      expectRegs($sformatf("rotate_%0d", k), 1'b1, pk[k % 4], 2'(k % 4), 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1);
    settle();
    checkOutput("idle_in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    checkOutput("drain_out_valid", 64'(bus.out_valid), 64'h0);

    // Backpressure: held packet stays stable, no requester accepted
    setSlot(2, mkPkt(28'h0ABCDEF, 3'b000, 3'b011));
    applyStimulus(1'b0, 4'b0100, 1'b0);
    settle();
    checkOutput("bp_first_in_ready", 64'(bus.in_ready), 64'h4);
    tick();
    expectRegs("bp_load", 1'b1, 34'h02AF37BC3, 2'd2, 1'b0);
    setSlot(2, pk2b);
    for (int k = 0; k < 5; k++) begin
      settle();
      checkOutput($sformatf("bp_in_ready_%0d", k), 64'(bus.in_ready), 64'h0);
      tick();
      checkOutput($sformatf("bp_valid_%0d", k), 64'(bus.out_valid), 64'h1);
      checkOutput($sformatf("bp_data_%0d", k), 64'(bus.out_data), 64'h02AF37BC3);
      checkOutput($sformatf("bp_src_%0d", k), 64'(bus.out_src), 64'h2);
    end
    applyStimulus(1'b0, 4'b0100, 1'b1);
    settle();
    checkOutput("bp_release_in_ready", 64'(bus.in_ready), 64'h4);
    tick();
    expectRegs("bp_reload", 1'b1, pk2b, 2'd2, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkOutput("bp_empty", 64'(bus.out_valid), 64'h0);

    // Drop: requester 1 sends dest==0, search then resumes at requester 2
    setSlot(1, mkPkt(28'h7777777, 3'd1, 3'd0));
    applyStimulus(1'b0, 4'b0010, 1'b0);
    settle();
    checkOutput("drop_in_ready", 64'(bus.in_ready), 64'h2);
    tick();
    checkOutput("drop_pulse_hi", 64'(bus.drop_pulse), 64'h1);
    checkOutput("drop_no_valid", 64'(bus.out_valid), 64'h0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick();
    checkOutput("drop_pulse_lo", 64'(bus.drop_pulse), 64'h0);
    checkOutput("drop_still_empty", 64'(bus.out_valid), 64'h0);
    loadSlots();
    applyStimulus(1'b0, 4'b1111, 1'b0);
    settle();
    checkOutput("after_drop_in_ready", 64'(bus.in_ready), 64'h4);
    tick();
    expectRegs("after_drop", 1'b1, pk[2], 2'd2, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();

    // Single requester 3 streaming back to back, pointer wraps to 0
    applyStimulus(1'b0, 4'b1000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      settle();
      checkOutput($sformatf("solo_in_ready_%0d", k), 64'(bus.in_ready), 64'h8);
      tick();
      checkOutput($sformatf("solo_valid_%0d", k), 64'(bus.out_valid), 64'h1);
      checkOutput($sformatf("solo_src_%0d", k), 64'(bus.out_src), 64'h3);
    end
    applyStimulus(1'b0, 4'b1111, 1'b1);
    settle();
    checkOutput("solo_rr_wrap", 64'(bus.in_ready), 64'h1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkOutput("solo_drained", 64'(bus.out_valid), 64'h0);

    // Reset while FULL under backpressure discards the held packet
    applyStimulus(1'b0, 4'b0010, 1'b0);
    settle();
    checkOutput("mid_in_ready", 64'(bus.in_ready), 64'h2);
    tick();
    expectRegs("mid_full", 1'b1, pk[1], 2'd1, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    settle();
    checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    expectRegs("mid_rst", 1'b0, '0, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkOutput("mid_post_valid", 64'(bus.out_valid), 64'h0);
    checkOutput("mid_post_data", 64'(bus.out_data), 64'h0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    settle();
    checkOutput("mid_rr_reset", 64'(bus.in_ready), 64'h1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick();

`ifdef TREE_ARB_GRANT_CNT_EN
    checkOutput("cnt_zero", 64'(grant_cnt), 64'h0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b1);
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("cnt_sat_0", 64'(grant_cnt[15:0]), 64'hFFFF);
    checkOutput("cnt_others", 64'(grant_cnt[63:16]), 64'h0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
